// File: rtl/asi_pkg.sv
// Shared types for the asi_* blocks: arbiter state, arbitration mode and read-return tag.
// The tag index width comes from ASI_RTAG_W and must cover $clog2(NUM_CH) of any user.
`ifndef ASI_RTAG_W
`define ASI_RTAG_W 4
`endif

package asi_pkg;

  typedef enum logic {
    MARB_IDLE  = 1'b0,
    MARB_GRANT = 1'b1
  } TYPE_MARB;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } TYPE_ARB_MODE;

  typedef struct packed {
    logic                   v;
    logic [`ASI_RTAG_W-1:0] idx;
  } rtag_t;

  // Increment modulo n, used for the round-robin pointer.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/asi_rr_pick.sv
// Combinational masked picker: lowest index (fixed) or first index at/after ptr (round-robin).
module asi_rr_pick
  import asi_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CHW    = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] mask,
  input  logic [CHW-1:0]    ptr,
  input  logic              mode,
  output logic [CHW-1:0]    idx,
  output logic              any
);

  logic [NUM_CH-1:0] cand;
  int unsigned       j;

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    cand = req & ~mask;
    any  = |cand;
    idx  = '0;
    j    = 0;
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      j = (mode == ARB_RR) ? (32'(ptr) + 32'(k)) % NUM_CH : 32'(k);
      if (cand[j]) begin
        idx = CHW'(j);
      end
    end
  end

endmodule

// File: rtl/asi_marb.sv
// N-channel user-memory arbiter: burst-long grants, address/data mux, tagged read return.
// Optional idle-grant watchdog enabled by defining ASI_MARB_TIMEOUT_EN.
module asi_marb
  import asi_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned AXI_DW     = 128,
  parameter int unsigned AXI_AW     = 40,
  parameter int unsigned AXI_WSTRBW = AXI_DW / 8,
  parameter int unsigned SLV_WS     = 1,
  parameter int unsigned ARB_MODE   = 1,
  parameter int unsigned TIMEOUT    = 256,
  parameter int unsigned CHW        = $clog2(NUM_CH)
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH-1:0]            ch_ce,
  input  logic [NUM_CH-1:0]            ch_we,
  input  logic [NUM_CH-1:0]            ch_last,
  input  logic [NUM_CH*AXI_AW-1:0]     ch_addr,
  input  logic [NUM_CH*AXI_DW-1:0]     ch_wdata,
  input  logic [NUM_CH*AXI_WSTRBW-1:0] ch_wstrb,
  output logic [NUM_CH-1:0]            ch_gnt,
  output logic [NUM_CH-1:0]            ch_rvalid,
  output logic [AXI_DW-1:0]            ch_rdata,
  output logic [AXI_AW-1:0]            usr_a,
  output logic                         usr_ce,
  output logic [AXI_DW-1:0]            usr_d,
  output logic [AXI_WSTRBW-1:0]        usr_we,
  input  logic [AXI_DW-1:0]            usr_q,
  output logic                         err_timeout
);

  localparam int unsigned TAGW = $bits(rtag_t) - 1;
  localparam logic        MODE = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

  TYPE_MARB          state_q, state_d;
  logic [CHW-1:0]    cur_q, cur_d, ptr_q, ptr_d, win;
  logic [NUM_CH-1:0] gnt_q, gnt_d, mask;
  logic              win_any, granted, done, timeout;
  rtag_t             push_tag, pipe_out;

  assign granted = (state_q == MARB_GRANT);
  assign usr_ce  = granted & ch_ce[cur_q];
  assign done    = (usr_ce & ch_last[cur_q]) | timeout;
  // The finishing channel is excluded so a handoff never re-grants it in the same cycle.
  assign mask    = granted ? (NUM_CH'(1) << cur_q) : '0;

  asi_rr_pick #(
    .NUM_CH(NUM_CH),
    .CHW   (CHW)
  ) u_pick (
    .req (ch_req),
    .mask(mask),
    .ptr (ptr_q),
    .mode(MODE),
    .idx (win),
    .any (win_any)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    if ((!granted || done) && win_any) begin
      state_d = MARB_GRANT;
      cur_d   = win;
      ptr_d   = CHW'(wrap_inc(32'(win), NUM_CH));
    end else if (granted && done) begin
      state_d = MARB_IDLE;
    end
    gnt_d = (state_d == MARB_GRANT) ? (NUM_CH'(1) << cur_d) : '0;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= MARB_IDLE;
      cur_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  assign ch_gnt = gnt_q;
  assign usr_a  = ch_addr[cur_q*AXI_AW +: AXI_AW];
  assign usr_d  = ch_wdata[cur_q*AXI_DW +: AXI_DW];
  assign usr_we = ch_wstrb[cur_q*AXI_WSTRBW +: AXI_WSTRBW] &
                  {AXI_WSTRBW{ch_we[cur_q] & usr_ce}};

  // Beats issued during reset are never tagged, so they cannot surface as rvalid later.
  assign push_tag = '{v: usr_ce & ~ch_we[cur_q] & ~ARESET, idx: TAGW'(cur_q)};

  if (SLV_WS == 0) begin : g_comb
    assign pipe_out = push_tag;
  end else begin : g_pipe
    rtag_t pipe_q [SLV_WS];

    always_ff @(posedge ACLK) begin
      if (ARESET) begin
        for (int i = 0; i < int'(SLV_WS); i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        pipe_q[0] <= push_tag;
        for (int i = 1; i < int'(SLV_WS); i++) begin
          pipe_q[i] <= pipe_q[i-1];
        end
      end
    end

    assign pipe_out = pipe_q[SLV_WS-1];
  end

  always_comb begin
    ch_rvalid = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      ch_rvalid[i] = pipe_out.v & (pipe_out.idx == TAGW'(i));
    end
  end

  assign ch_rdata = usr_q;

`ifdef ASI_MARB_TIMEOUT_EN
  localparam int unsigned TOW = $clog2(TIMEOUT + 1);

  logic [TOW-1:0] to_cnt_q, to_cnt_d;

  // Fires on the TIMEOUT-th consecutive beatless cycle of a grant.
  assign timeout  = granted & ~usr_ce & (to_cnt_q == TOW'(TIMEOUT - 1));
  assign to_cnt_d = (!granted || usr_ce || timeout) ? '0 : to_cnt_q + TOW'(1);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign err_timeout = timeout;
`else
  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_asi_marb.sv
// Bench for asi_marb: a round-robin/SLV_WS=3 and a fixed-priority/SLV_WS=1 instance share stimulus.
module tb_asi_marb;

  localparam int TO = 8;
  localparam int WS [2] = '{3, 1};
  localparam int MD [2] = '{1, 0};

  logic         clk, rst;
  logic [3:0]   req, ce, we, last;
  logic [159:0] addr;
  logic [511:0] wdata;
  logic [63:0]  wstrb;

  logic [3:0]   gnt_o [2];
  logic [3:0]   rv_o [2];
  logic [127:0] rdata_o [2];
  logic [39:0]  usr_a_o [2];
  logic         ce_o [2];
  logic [127:0] usr_d_o [2];
  logic [15:0]  we_o [2];
  logic [127:0] usr_q_i [2];
  logic         err_o [2];
  logic [39:0]  a_dly [2][4];

  int n_cmp, n_bad, cyc;

  bit          m_gr [2];
  int          m_cur [2];
  int          m_ptr [2];
  int          m_idle [2];
  bit          pv [2][8];
  int          pidx [2][8];
  logic [39:0] pad [2][8];

  function automatic logic [127:0] memf(input logic [39:0] a);
    return {8'hA5, a, ~a, a};
  endfunction

  asi_marb #(
    .NUM_CH(4), .AXI_DW(128), .AXI_AW(40), .SLV_WS(3), .ARB_MODE(1), .TIMEOUT(TO)
  ) u_rr (
    .ACLK(clk), .ARESET(rst), .ch_req(req), .ch_ce(ce), .ch_we(we), .ch_last(last),
    .ch_addr(addr), .ch_wdata(wdata), .ch_wstrb(wstrb), .ch_gnt(gnt_o[0]),
    .ch_rvalid(rv_o[0]), .ch_rdata(rdata_o[0]), .usr_a(usr_a_o[0]), .usr_ce(ce_o[0]),
    .usr_d(usr_d_o[0]), .usr_we(we_o[0]), .usr_q(usr_q_i[0]), .err_timeout(err_o[0])
  );

  asi_marb #(
    .NUM_CH(4), .AXI_DW(128), .AXI_AW(40), .SLV_WS(1), .ARB_MODE(0), .TIMEOUT(TO)
  ) u_fx (
    .ACLK(clk), .ARESET(rst), .ch_req(req), .ch_ce(ce), .ch_we(we), .ch_last(last),
    .ch_addr(addr), .ch_wdata(wdata), .ch_wstrb(wstrb), .ch_gnt(gnt_o[1]),
    .ch_rvalid(rv_o[1]), .ch_rdata(rdata_o[1]), .usr_a(usr_a_o[1]), .usr_ce(ce_o[1]),
    .usr_d(usr_d_o[1]), .usr_we(we_o[1]), .usr_q(usr_q_i[1]), .err_timeout(err_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM stand-in: returns memf(address) WS cycles after the address was presented.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      a_dly[d][0] <= usr_a_o[d];
      for (int k = 1; k < 4; k++) a_dly[d][k] <= a_dly[d][k-1];
    end
  end
  assign usr_q_i[0] = memf(a_dly[0][2]);
  assign usr_q_i[1] = memf(a_dly[1][0]);

  task automatic chk(input string nm, input int d, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", nm, d, cyc, got, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] cand, input int md, input int ptr);
    for (int k = 0; k < 4; k++) begin
      int j = md != 0 ? (ptr + k) % 4 : k;
      if (cand[j]) return j;
    end
    return -1;
  endfunction

  // Predict this cycle's outputs from the model, compare, then advance the model one clock.
  task automatic model_cycle();
    for (int d = 0; d < 2; d++) begin
      int c, s, w;
      logic [3:0] eg, erv, cand;
      logic ece, eto, done;
      logic [15:0] ewe;
      logic [127:0] erd;
      c   = m_cur[d];
      eg  = m_gr[d] ? 4'(1 << c) : 4'b0;
      ece = m_gr[d] && ce[c];
      ewe = (ece && we[c]) ? wstrb[c*16 +: 16] : 16'h0;
      eto = 1'b0;
`ifdef ASI_MARB_TIMEOUT_EN
      eto = m_gr[d] && !ece && (m_idle[d] + 1 == TO);
`endif
      if (ece && !we[c] && !rst) begin
        s = (cyc + WS[d]) % 8;
        pv[d][s] = 1'b1;
        pidx[d][s] = c;
        pad[d][s] = addr[c*40 +: 40];
      end
      s   = cyc % 8;
      erv = pv[d][s] ? 4'(1 << pidx[d][s]) : 4'b0;
      erd = memf(pad[d][s]);
      pv[d][s] = 1'b0;
      chk("gnt", d, gnt_o[d], eg);
      chk("usr_ce", d, ce_o[d], ece);
      chk("usr_we", d, we_o[d], ewe);
      chk("rvalid", d, rv_o[d], erv);
      chk("err_timeout", d, err_o[d], eto);
      if (m_gr[d]) begin
        chk("usr_a", d, usr_a_o[d], addr[c*40 +: 40]);
        chk("usr_d", d, usr_d_o[d], wdata[c*128 +: 128]);
      end
      if (erv != 4'b0) chk("rdata", d, rdata_o[d], erd);
      if (rst) begin
        m_gr[d] = 0; m_cur[d] = 0; m_ptr[d] = 0; m_idle[d] = 0;
        for (int k = 0; k < 8; k++) pv[d][k] = 1'b0;
      end else begin
        done = m_gr[d] && ((ece && last[c]) || eto);
        if (!m_gr[d] || ece || done) m_idle[d] = 0;
        else m_idle[d]++;
        if (!m_gr[d] || done) begin
          cand = req;
          if (m_gr[d]) cand[c] = 1'b0;
          w = pick(cand, MD[d], m_ptr[d]);
          if (w >= 0) begin
            m_gr[d] = 1; m_cur[d] = w; m_ptr[d] = (w + 1) % 4;
          end else begin
            m_gr[d] = 0;
          end
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq, cv, wv, lv);
    @(posedge clk);
    #1;
    rst = r; req = rq; ce = cv; we = wv; last = lv;
    @(negedge clk);
    model_cycle();
    cyc++;
  endtask

  task automatic set_ch(input int i, input logic [39:0] a, input logic [15:0] st);
    addr[i*40 +: 40]    = a;
    wdata[i*128 +: 128] = {a[31:0], ~a[31:0], 32'hD0D0_0000 | 32'(i), a[31:0]};
    wstrb[i*16 +: 16]   = st;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    rst = 1'b1; req = '0; ce = '0; we = '0; last = '0;
    addr = '0; wdata = '0; wstrb = '0;
    for (int d = 0; d < 2; d++) begin
      m_gr[d] = 0; m_cur[d] = 0; m_ptr[d] = 0; m_idle[d] = 0;
      for (int k = 0; k < 8; k++) begin
        pv[d][k] = 0; pidx[d][k] = 0; pad[d][k] = '0;
      end
    end
    @(posedge clk);
    step(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("reset_gnt", 0, gnt_o[0], 4'b0000);
    chk("reset_rvalid", 1, rv_o[1], 4'b0000);

    // All four channels request together, two-beat read bursts each.
    for (int i = 0; i < 4; i++) set_ch(i, 40'h10 + 40'h100 * i, 16'hFFFF);
    step(0, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    step(0, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
    chk("t1_gnt0", 0, gnt_o[0], 4'b0001);
    step(0, 4'b1111, 4'b1111, 4'b0000, 4'b0001);
    step(0, 4'b1110, 4'b1111, 4'b0000, 4'b0000);
    chk("t1_gnt1", 0, gnt_o[0], 4'b0010);
    chk("t1_usr_a", 0, usr_a_o[0], 40'h110);
    step(0, 4'b1110, 4'b1111, 4'b0000, 4'b0010);
    chk("t1_rv_ch0", 0, rv_o[0], 4'b0001);
    chk("t1_rdata_ch0", 0, rdata_o[0], memf(40'h10));
    step(0, 4'b1100, 4'b1111, 4'b0000, 4'b0000);
    chk("t1_gnt2", 0, gnt_o[0], 4'b0100);
    chk("t1_gnt2_fx", 1, gnt_o[1], 4'b0100);
    step(0, 4'b1100, 4'b1111, 4'b0000, 4'b0100);
    step(0, 4'b1000, 4'b1111, 4'b0000, 4'b0000);
    chk("t1_gnt3", 0, gnt_o[0], 4'b1000);
    step(0, 4'b1000, 4'b1111, 4'b0000, 4'b1000);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("t1_idle", 0, gnt_o[0], 4'b0000);
    repeat (3) step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // ch3 bursting, ch0/ch1 join at its last beat; then RR and fixed diverge.
    step(0, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b1000, 4'b1000, 4'b0000, 4'b0000);
    step(0, 4'b1011, 4'b1011, 4'b0000, 4'b1000);
    step(0, 4'b1011, 4'b1011, 4'b0000, 4'b0001);
    chk("t2_gnt0_fx", 1, gnt_o[1], 4'b0001);
    step(0, 4'b1010, 4'b1010, 4'b0000, 4'b0010);
    chk("t2_gnt1_fx", 1, gnt_o[1], 4'b0010);
    step(0, 4'b1000, 4'b1000, 4'b0000, 4'b1000);
    chk("t2_gnt3_fx", 1, gnt_o[1], 4'b1000);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("t2_idle_fx", 1, gnt_o[1], 4'b0000);
    step(0, 4'b0011, 4'b0011, 4'b0000, 4'b0000);
    step(0, 4'b0011, 4'b0011, 4'b0000, 4'b0001);
    step(0, 4'b1001, 4'b1011, 4'b0000, 4'b0010);
    step(0, 4'b0000, 4'b1001, 4'b0000, 4'b1001);
    chk("t2_rr_ch3", 0, gnt_o[0], 4'b1000);
    chk("t2_fx_ch0", 1, gnt_o[1], 4'b0001);
    repeat (4) step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Write beat from ch0 while non-granted ch2 strobes ce.
    set_ch(0, 40'h40, 16'h00FF);
    set_ch(2, 40'h240, 16'hFFFF);
    step(0, 4'b0001, 4'b0000, 4'b0101, 4'b0000);
    step(0, 4'b0001, 4'b0101, 4'b0101, 4'b0000);
    chk("t4_usr_we", 0, we_o[0], 16'h00FF);
    chk("t4_usr_d", 1, usr_d_o[1], {32'h40, ~32'h40, 32'hD0D0_0000, 32'h40});
    step(0, 4'b0001, 4'b0100, 4'b0101, 4'b0000);
    chk("t4_ce_ignored", 0, ce_o[0], 1'b0);
    chk("t4_we_ignored", 1, we_o[1], 16'h0000);
    step(0, 4'b0001, 4'b0001, 4'b0101, 4'b0001);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // ch1 read then back-to-back handoff to ch2 read.
    set_ch(1, 40'h100, 16'hFFFF);
    set_ch(2, 40'h200, 16'hFFFF);
    step(0, 4'b0110, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b0110, 4'b0110, 4'b0000, 4'b0010);
    step(0, 4'b0100, 4'b0100, 4'b0000, 4'b0100);
    chk("t3_rv_fx", 1, rv_o[1], 4'b0010);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("t3_rv1", 0, rv_o[0], 4'b0010);
    chk("t3_rd1", 0, rdata_o[0], memf(40'h100));
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("t3_rv2", 0, rv_o[0], 4'b0100);
    chk("t3_rd2", 0, rdata_o[0], memf(40'h200));
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Reset with reads in flight; afterwards the RR pointer must be back at 0.
    set_ch(0, 40'h300, 16'hFFFF);
    step(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    step(0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    step(1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("t5_gnt_rr", 0, gnt_o[0], 4'b0000);
    chk("t5_gnt_fx", 1, gnt_o[1], 4'b0000);
    chk("t5_rv_a", 0, rv_o[0], 4'b0000);
    step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("t5_rv_b", 0, rv_o[0], 4'b0000);
    step(0, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
    step(0, 4'b1001, 4'b1001, 4'b0000, 4'b0001);
    chk("t5_ptr0", 0, gnt_o[0], 4'b0001);
    step(0, 4'b1000, 4'b1000, 4'b0000, 4'b1000);
    repeat (4) step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // ch0 granted but silent while ch1 waits.
    step(0, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
    for (int i = 1; i <= 8; i++) begin
      step(0, 4'b0011, 4'b0000, 4'b0000, 4'b0000);
`ifdef ASI_MARB_TIMEOUT_EN
      if (i == 7) chk("t6_no_err_early", 0, err_o[0], 1'b0);
      if (i == 8) chk("t6_err_pulse", 0, err_o[0], 1'b1);
`endif
    end
    step(0, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
`ifdef ASI_MARB_TIMEOUT_EN
    chk("t6_handoff", 0, gnt_o[0], 4'b0010);
`else
    chk("t6_held", 0, gnt_o[0], 4'b0001);
    chk("t6_no_err", 0, err_o[0], 1'b0);
`endif
    step(0, 4'b0000, 4'b0001, 4'b0000, 4'b0001);
    repeat (4) step(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
